// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4,
    RUN   = 3'd5,
    ERROR = 3'd6
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned LEN_W    = 16;

  function automatic logic is_busy_state(input state_e s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: DEPTH x 32, synchronous write, asynchronous read.
module imem_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader and fetch front end for the SLRV core.
// Optional checksum trailer enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] ins_mem_addr,
  output logic [31:0]       ins_mem_data,
  output logic              ins_mem_en,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = CSUM;
`else
  localparam state_e POST_DATA = RUN;
`endif

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_q, word_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               rx_ready_q, ins_mem_en_q, cpu_reset_q, busy_q, error_q;
  logic               accept;
  logic               ram_we;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic [LEN_W-1:0]   len_rx;

  assign accept = rx_valid & rx_ready_q;
  assign len_rx = {rx_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    wr_ptr_d   = wr_ptr_q;
    words_d    = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    ram_we     = 1'b0;
    ram_wdata  = {rx_data, word_q};

    if (load_start) begin
      state_d    = LEN0;
      len_lo_d   = '0;
      len_d      = '0;
      byte_cnt_d = '0;
      wr_ptr_d   = '0;
      words_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = '0;
`endif
    end else begin
      case (state_q)
        LEN0: begin
          if (accept) begin
            len_lo_d = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d    = sum_q + rx_data;
`endif
            state_d  = LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len_d = len_rx;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d = sum_q + rx_data;
`endif
            if (len_rx == '0) begin
              state_d = POST_DATA;
            end else if (32'(len_rx) > DEPTH) begin
              state_d = ERROR;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d = sum_q + rx_data;
`endif
            // The 4th byte completes the word straight from rx_data, so the
            // packer only ever holds the lower three bytes.
            if (byte_cnt_q == 2'd3) begin
              ram_we     = 1'b1;
              byte_cnt_d = '0;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              words_d    = words_q + 1'b1;
              if (32'(words_q) + 32'd1 == 32'(len_q)) begin
                state_d = POST_DATA;
              end
            end else begin
              word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            state_d = (8'(sum_q + rx_data) == 8'h00) ? RUN : ERROR;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      wr_ptr_q     <= '0;
      words_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
      rx_ready_q   <= 1'b0;
      ins_mem_en_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      wr_ptr_q     <= wr_ptr_d;
      words_q      <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
      // Outputs decode the next state so they change together with state_q.
      rx_ready_q   <= is_busy_state(state_d);
      busy_q       <= is_busy_state(state_d);
      ins_mem_en_q <= (state_d == RUN);
      cpu_reset_q  <= (state_d != RUN);
      error_q      <= (state_d == ERROR);
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (ins_mem_addr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    ins_mem_data = NOP_INSN;
    if ((state_q == RUN) && ({1'b0, ins_mem_addr} < words_q)) begin
      ins_mem_data = ram_rdata;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign ins_mem_en   = ins_mem_en_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations, a monitor compares.
module tb_imem_loader;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] ins_mem_addr;
  logic [31:0]   ins_mem_data;
  logic          ins_mem_en;
  logic          cpu_reset;
  logic          busy;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_start   (load_start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .ins_mem_addr (ins_mem_addr),
    .ins_mem_data (ins_mem_data),
    .ins_mem_en   (ins_mem_en),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef enum logic [3:0] {K_DATA, K_EN, K_CRST, K_RDY, K_BUSY, K_ERR, K_WORDS} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] bq[$];

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_DATA:  return ins_mem_data;
      K_EN:    return 32'(ins_mem_en);
      K_CRST:  return 32'(cpu_reset);
      K_RDY:   return 32'(rx_ready);
      K_BUSY:  return 32'(busy);
      K_ERR:   return 32'(error);
      K_WORDS: return 32'(words_loaded);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input kind_e k);
    case (k)
      K_DATA:  return "ins_mem_data";
      K_EN:    return "ins_mem_en";
      K_CRST:  return "cpu_reset";
      K_RDY:   return "rx_ready";
      K_BUSY:  return "busy";
      K_ERR:   return "error";
      K_WORDS: return "words_loaded";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: one expectation per falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    ins_mem_addr = '0;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.kind == K_DATA) begin
          ins_mem_addr = e.addr[AW-1:0];
          #1;
        end
        act = sample(e.kind);
        compared++;
        if (act !== e.exp) begin
          mismatched++;
          $display("FAIL %s addr=%0d got=%h expected=%h t=%0t",
                   kname(e.kind), e.addr, act, e.exp, $time);
        end
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
      sb.delete();
    end
    #2;
  endtask

  // Offer one byte; rx_valid is raised only once rx_ready is seen so exactly one transfer happens.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (rx_ready) begin
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout byte=%h got=no_ready expected=ready", b);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
      rx_data = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1;
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
  endtask

  // Streams bq (plus a checksum trailer when enabled and requested); checks the core
  // is still held in reset just before the final byte.
  task automatic send_stream(input int unsigned max_gap, input bit with_csum,
                             input logic [7:0] csum_delta);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    int         n = bq.size();
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (with_csum) n = n + 1;
`endif
    for (int i = 0; i < n; i++) begin
      if (i < bq.size()) b = bq[i];
      else               b = 8'(8'h00 - sum + csum_delta);
      sum = sum + b;
      if (i == n - 1) begin
        expect_val(K_CRST, 0, 1);
        expect_val(K_EN, 0, 0);
        drain();
      end
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send(b);
    end
  endtask

  task automatic start_checks();
    pulse_start();
    expect_val(K_ERR, 0, 0);
    expect_val(K_BUSY, 0, 1);
    expect_val(K_RDY, 0, 1);
    expect_val(K_CRST, 0, 1);
    expect_val(K_WORDS, 0, 0);
    drain();
  endtask

  task automatic prog2_checks();
    expect_val(K_CRST, 0, 0);
    expect_val(K_EN, 0, 1);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_WORDS, 0, 2);
    expect_val(K_DATA, 0, 32'h0010_0093);
    expect_val(K_DATA, 1, 32'h0020_0113);
    expect_val(K_DATA, 2, NOP);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    expect_val(K_EN, 0, 0);
    expect_val(K_CRST, 0, 1);
    expect_val(K_DATA, 0, NOP);
    expect_val(K_DATA, 7, NOP);
    expect_val(K_RDY, 0, 0);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_ERR, 0, 0);
    expect_val(K_WORDS, 0, 0);
    drain();

    // Two-word program, back-to-back bytes
    start_checks();
    bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    send_stream(0, 1'b1, 8'h00);
    prog2_checks();

    // Bytes offered in RUN are ignored
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    idle(3);
    rx_valid = 1'b0;
    expect_val(K_RDY, 0, 0);
    expect_val(K_EN, 0, 1);
    expect_val(K_WORDS, 0, 2);
    expect_val(K_DATA, 1, 32'h0020_0113);
    drain();

    // Empty program
    start_checks();
    bq = '{8'h00, 8'h00};
    send_stream(0, 1'b1, 8'h00);
    expect_val(K_EN, 0, 1);
    expect_val(K_CRST, 0, 0);
    expect_val(K_WORDS, 0, 0);
    expect_val(K_DATA, 0, NOP);
    drain();

    // N = DEPTH+1 is rejected after LEN1
    start_checks();
    bq = '{8'h01, 8'h02};
    send_stream(0, 1'b0, 8'h00);
    expect_val(K_ERR, 0, 1);
    expect_val(K_CRST, 0, 1);
    expect_val(K_EN, 0, 0);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_RDY, 0, 0);
    drain();

    // N = DEPTH accepted, aborted mid-word, then a fresh one-word load
    start_checks();
    send(8'h00);
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    expect_val(K_BUSY, 0, 1);
    expect_val(K_ERR, 0, 0);
    expect_val(K_WORDS, 0, 0);
    drain();
    start_checks();
    bq = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stream(0, 1'b1, 8'h00);
    expect_val(K_EN, 0, 1);
    expect_val(K_WORDS, 0, 1);
    expect_val(K_DATA, 0, 32'h0000_006F);
    expect_val(K_DATA, 1, NOP);
    drain();

    // Two-word program with random idle gaps between bytes
    start_checks();
    bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    send_stream(3, 1'b1, 8'h00);
    prog2_checks();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum trailer
    start_checks();
    send_stream(0, 1'b1, 8'h01);
    expect_val(K_ERR, 0, 1);
    expect_val(K_CRST, 0, 1);
    expect_val(K_EN, 0, 0);
    expect_val(K_DATA, 0, NOP);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
